// File: rtl/sram_bus_arbiter_pkg.sv
// Shared CPU definitions used by the SRAM bus arbiter.
//   Word_t / Mask_t / Bit_t : common datapath types (32-bit word, byte mask, single bit)
//   Sram_addr_t             : SRAM word address at the default width
//   Arb_state_t             : arbiter FSM states
//   SRAM_WAIT_DEFAULT       : default number of SRAM wait cycles per access
package cpu_defines;

  localparam int SRAM_ADDR_W_DEFAULT = 20;
  localparam int SRAM_WAIT_DEFAULT   = 2;

  typedef logic [31:0]                    Word_t;
  typedef logic [3:0]                     Mask_t;
  typedef logic                           Bit_t;
  typedef logic [SRAM_ADDR_W_DEFAULT-1:0] Sram_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    D_READ,
    D_WRITE,
    I_READ
  } Arb_state_t;

endpackage

// File: rtl/sram_bus_arbiter.sv
// Shares one external asynchronous SRAM between the instruction-fetch port
// and the data port. Data accesses win over fetches; each access holds the
// SRAM for WAIT_CYCLES+1 cycles and completes with a one-cycle ack.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   if_req_i/if_addr_i        : fetch request and byte address
//   if_data_o/if_ack_o        : fetch read data and completion pulse
//   d_re_i/d_we_i/d_addr_i    : data read/write request and byte address
//   d_wdata_i/d_mask_i        : write data and active-high byte enables
//   d_rdata_o/d_ack_o         : data read data and completion pulse
//   sram_*                    : board SRAM pins (control strobes active-low)
//   stallreq_o                : pipeline stall request while a port waits
module sram_bus_arbiter
  import cpu_defines::*;
#(
  parameter int WAIT_CYCLES = SRAM_WAIT_DEFAULT,
  parameter int SRAM_ADDR_W = SRAM_ADDR_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req_i,
  input  logic [31:0]            if_addr_i,
  output logic [31:0]            if_data_o,
  output logic                   if_ack_o,
  input  logic                   d_re_i,
  input  logic                   d_we_i,
  input  logic [31:0]            d_addr_i,
  input  logic [31:0]            d_wdata_i,
  input  logic [3:0]             d_mask_i,
  output logic [31:0]            d_rdata_o,
  output logic                   d_ack_o,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  output logic [31:0]            sram_wdata_o,
  input  logic [31:0]            sram_rdata_i,
  output logic                   sram_ce_n_o,
  output logic                   sram_oe_n_o,
  output logic                   sram_we_n_o,
  output logic [3:0]             sram_be_n_o,
  output logic                   stallreq_o
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

  Arb_state_t             r_state;
  Arb_state_t             w_nextState;
  logic [3:0]             r_cnt;
  logic [SRAM_ADDR_W-1:0] r_addr;
  Word_t                  r_wdata;
  Mask_t                  r_mask;
  Word_t                  r_ifData;
  Word_t                  r_dRdata;
  Bit_t                   r_ifAck;
  Bit_t                   r_dAck;
  Bit_t                   w_dReq;
  Bit_t                   w_dPending;
  Bit_t                   w_ifPending;
  Bit_t                   w_cntZero;
  Bit_t                   w_launch;
  Bit_t                   w_done;
  logic                   w_unusedAddrBits;

  // A port's request is masked while its own ack is high, so a request the
  // pipeline has not yet dropped cannot launch a second access.
  assign w_dReq      = d_re_i | d_we_i;
  assign w_dPending  = w_dReq & ~r_dAck;
  assign w_ifPending = if_req_i & ~r_ifAck;
  assign w_cntZero   = (r_cnt == 4'd0);
  assign w_launch    = (r_state == IDLE) && (w_nextState != IDLE);
  assign w_done      = (r_state != IDLE) && w_cntZero;

  // Byte-offset and upper address bits never reach the SRAM.
  assign w_unusedAddrBits = ^{if_addr_i[31:SRAM_ADDR_W+2], if_addr_i[1:0],
                              d_addr_i[31:SRAM_ADDR_W+2], d_addr_i[1:0]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: data beats fetch in IDLE; an access runs until cnt hits 0.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_dPending) begin
          w_nextState = d_we_i ? D_WRITE : D_READ;
        end else if (w_ifPending) begin
          w_nextState = I_READ;
        end
      end
      default: begin
        if (w_cntZero) begin
          w_nextState = IDLE;
        end
      end
    endcase
  end

  // Wait counter, latched access operands, read-data capture and acks.
  // Read data is sampled at the edge that ends the cnt==0 cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_mask   <= '0;
      r_ifData <= '0;
      r_dRdata <= '0;
      r_ifAck  <= 1'b0;
      r_dAck   <= 1'b0;
    end else begin
      if (w_launch) begin
        r_cnt   <= CNT_LOAD;
        r_addr  <= (w_nextState == I_READ) ? if_addr_i[SRAM_ADDR_W+1:2]
                                           : d_addr_i[SRAM_ADDR_W+1:2];
        r_wdata <= d_wdata_i;
        r_mask  <= d_mask_i;
      end else if (!w_cntZero) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_ifAck <= w_done && (r_state == I_READ);
      r_dAck  <= w_done && ((r_state == D_READ) || (r_state == D_WRITE));
      if (w_done && (r_state == I_READ)) begin
        r_ifData <= sram_rdata_i;
      end
      if (w_done && (r_state == D_READ)) begin
        r_dRdata <= sram_rdata_i;
      end
    end
  end

  // SRAM strobes decode from state and counter; we_n rises in the cnt==0
  // cycle so address and data are held past the end of the write pulse.
  always_comb begin
    sram_ce_n_o = 1'b1;
    sram_oe_n_o = 1'b1;
    sram_we_n_o = 1'b1;
    sram_be_n_o = 4'hF;
    case (r_state)
      D_READ, I_READ: begin
        sram_ce_n_o = 1'b0;
        sram_oe_n_o = 1'b0;
        sram_be_n_o = 4'h0;
      end
      D_WRITE: begin
        sram_ce_n_o = 1'b0;
        sram_we_n_o = w_cntZero;
        sram_be_n_o = ~r_mask;
      end
      default: ;
    endcase
  end

  assign sram_addr_o  = r_addr;
  assign sram_wdata_o = r_wdata;
  assign if_data_o    = r_ifData;
  assign d_rdata_o    = r_dRdata;
  assign if_ack_o     = r_ifAck;
  assign d_ack_o      = r_dAck;
  assign stallreq_o   = rst & (w_ifPending | w_dPending);

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one external asynchronous SRAM between the CPU instruction-fetch port (rom_*) and the data port (ram_*).
- Sequences multi-cycle SRAM accesses with a wait-state counter, gives data accesses priority, returns read data with an ack pulse, and raises a stall request to ctrl while any requester is waiting.
- Sits between cpu and the board SRAM pins.

Parameters:
- WAIT_CYCLES, 2, number of SRAM wait cycles per access; legal range 1..15.
- SRAM_ADDR_W, 20, SRAM word-address width.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  fetch request; held until if_ack_o.
- if_addr_i  in  32  fetch byte address.
- if_data_o  out  32  fetch read data; valid while if_ack_o=1.
- if_ack_o  out  1  one-cycle fetch completion pulse.
- d_re_i  in  1  data read request.
- d_we_i  in  1  data write request.
- d_addr_i  in  32  data byte address.
- d_wdata_i  in  32  write data.
- d_mask_i  in  4  byte enables, active-high.
- d_rdata_o  out  32  data read data; valid while d_ack_o=1.
- d_ack_o  out  1  one-cycle data completion pulse.
- sram_addr_o  out  SRAM_ADDR_W  SRAM word address.
- sram_wdata_o  out  32  SRAM write data.
- sram_rdata_i  in  32  SRAM read data.
- sram_ce_n_o  out  1  chip enable, active-low.
- sram_oe_n_o  out  1  output enable, active-low.
- sram_we_n_o  out  1  write enable, active-low.
- sram_be_n_o  out  4  byte enables, active-low.
- stallreq_o  out  1  to ctrl; asks the pipeline to stall.

Behaviour:
- Reset (rst=0, asynchronous): FSM enters IDLE and the counter clears. sram_ce_n/oe_n/we_n=1, sram_be_n=4'hF, sram_addr/wdata=0, both acks=0, if_data/d_rdata=0.
- Reset asserted mid-access aborts the access immediately. No ack is issued and we_n returns high at once.
- Data request d_req = d_re_i | d_we_i. If both re and we are asserted, the access is a write.
- FSM states: IDLE, D_READ, D_WRITE, I_READ.
- Transitions from IDLE, evaluated each cycle:
  - d_req and not d_ack_o: go to D_WRITE if we, else D_READ.
  - else if_req_i and not if_ack_o: go to I_READ.
  - else stay in IDLE.
- A requester's request is ignored in the cycle its own ack is high. This prevents a double issue while the pipeline is still releasing the request.
- On entering an access state: latch addr, wdata and mask into output registers and load cnt=WAIT_CYCLES. The access state then lasts WAIT_CYCLES+1 cycles (cnt counts down to 0).
- At cnt==0 the FSM returns to IDLE.
- Outputs during an access:
  - sram_addr_o = addr[SRAM_ADDR_W+1:2]; bits [1:0] are ignored.
  - ce_n=0 for the whole access.
  - Reads: oe_n=0 and be_n=4'h0.
  - Writes: oe_n=1, be_n=~mask, wdata driven for all cycles. we_n=0 while cnt>=1 and we_n=1 at cnt==0, giving address/data hold.
- Read data: sram_rdata_i is sampled at the edge ending the cnt==0 cycle into if_data_o or d_rdata_o. That register holds its value until the next read of the same port completes.
- The ack pulses high for exactly the cycle after cnt==0, which is an IDLE cycle; a new access may launch in that same cycle.
- Latency from a request seen in IDLE to ack is WAIT_CYCLES+2 cycles (4 at the default).
- Priority: data always wins over fetch when both are pending in IDLE. There is no preemption of an in-flight access.
- Fetch starvation is acceptable: the pipeline stall bounds it.
- stallreq_o = (if_req_i & ~if_ack_o) | (d_req & ~d_ack_o). It is combinational and 0 during reset.
- Back-to-back requests from one port: the second access starts 1 cycle after that port's ack; the other port's request may take that slot first.

Decomposition:
- Shared package cpu_defines:
  - Sram_addr_t (logic[SRAM_ADDR_W-1:0])
  - Arb_state_t enum {IDLE, D_READ, D_WRITE, I_READ}
  - SRAM_WAIT_DEFAULT constant
  - reuse of the Word_t, Mask_t and Bit_t typedefs
- Keep the block flat with no sub-module. The counter and FSM are tightly coupled.

Test Plan:
- Fetch read only, WAIT_CYCLES=2: if_req at cycle 0, addr 0x0000_0010, SRAM returns 0xDEADBEEF. Required: sram_addr=0x4 and oe_n=0 during cycles 1-3; if_ack=1 only in cycle 4 with if_data=0xDEADBEEF; stallreq=1 during cycles 0-3.
- Simultaneous fetch and data read at cycle 0. Required: data accesses in cycles 1-3 with d_ack in cycle 4; fetch accesses in cycles 5-7 with if_ack in cycle 8; stallreq stays 1 through cycle 7.
- Data write, addr 0x8, wdata 0x11223344, mask 4'b0011. Required: be_n=4'b1100 and wdata stable for cycles 1-3; we_n low in cycles 1-2 and high in cycle 3; d_ack in cycle 4; oe_n stays 1.
- Held request across ack: d_re held through cycle 4. Required: exactly one access is issued per ack; a request still held in cycle 5 starts a second access in cycle 6, with ack in cycle 9.
- Reset in cycle 2 of a write. Required: same cycle, we_n=1, ce_n=1, no ack, state IDLE; after release, a new read completes with normal latency.
- WAIT_CYCLES=1 sweep: single read. Required: ack in cycle 3, with we_n low for 1 cycle on writes.
